// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus bundle: fetch handshake, datapath feedback, datapath controls.
// master = control unit side, slave = fetch/datapath/testbench side.
interface multicycle_control_unit_if #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int CNT_WIDTH        = 16
);
  logic [INSTRUCTION_SIZE-1:0] instruction;
  logic                        instr_valid;
  logic                        cu_instr_ready;
  logic                        dm_ready;
  logic                        alu_zero;
  logic [4:0]                  cu_rf_addr_a;
  logic [4:0]                  cu_rf_addr_b;
  logic [4:0]                  cu_rf_write_addr;
  logic                        cu_rf_write_en;
  logic [WORDSIZE-1:0]         cu_immediate;
  logic                        cu_mux_0_sel;
  logic                        cu_mux_1_sel;
  logic                        cu_mux_2_sel;
  logic [2:0]                  cu_alu_operation;
  logic                        cu_dm_write_en;
  logic                        cu_dm_read_en;
  logic                        cu_branch_taken;
  logic                        cu_illegal;
  logic [CNT_WIDTH-1:0]        cu_retired;

  modport master (
    input  instruction, instr_valid, dm_ready, alu_zero,
    output cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b,
    output cu_rf_write_addr, cu_rf_write_en, cu_immediate,
    output cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
    output cu_alu_operation, cu_dm_write_en, cu_dm_read_en,
    output cu_branch_taken, cu_illegal, cu_retired
  );

  modport slave (
    output instruction, instr_valid, dm_ready, alu_zero,
    input  cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b,
    input  cu_rf_write_addr, cu_rf_write_en, cu_immediate,
    input  cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
    input  cu_alu_operation, cu_dm_write_en, cu_dm_read_en,
    input  cu_branch_taken, cu_illegal, cu_retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Ports: clk, rst_n (async, active-low), bus (master modport of the CU bus).
module multicycle_control_unit #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int CNT_WIDTH        = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK
  } state_e;

  typedef enum logic [2:0] {
    C_ILL, C_LOAD, C_STORE, C_RTYPE, C_ADDI, C_BEQ
  } cls_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_e                      state_q, state_d;
  cls_e                        cls_q, cls_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic                        retire;

  logic [6:0]          opc, f7;
  logic [2:0]          f3;
  logic [2:0]          rop_d, alu_d;
  logic [WORDSIZE-1:0] imm_d;

  logic                 ready_q, ill_q;
  logic                 rf_we_q, dm_re_q, dm_we_q;
  logic                 mux1_q, mux2_q;
  logic [2:0]           alu_q;
  logic [4:0]           ra_q, rb_q, rw_q;
  logic [WORDSIZE-1:0]  imm_q;
  logic [CNT_WIDTH-1:0] ret_q;

  assign opc = instr_d[6:0];
  assign f3  = instr_d[14:12];
  assign f7  = instr_d[31:25];

  // Next state; the port word is only looked at on acceptance.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    retire  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          instr_d = bus.instruction;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = (cls_q == C_ILL) ? FETCH : EXECUTE;
      end
      EXECUTE: begin
        unique case (cls_q)
          C_LOAD, C_STORE: state_d = MEMORY;
          C_BEQ: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
          default: state_d = WRITEBACK;
        endcase
      end
      MEMORY: begin
        if (bus.dm_ready) begin
          if (cls_q == C_LOAD) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Decode of the word that will be latched next cycle.
  always_comb begin
    cls_d = C_ILL;
    rop_d = ALU_ADD;
    unique case (1'b1)
      opc == OP_LOAD:  cls_d = C_LOAD;
      opc == OP_STORE: cls_d = C_STORE;
      opc == OP_R: begin
        unique case ({f7, f3})
          {7'b0000000, 3'b000}: begin
            cls_d = C_RTYPE;
            rop_d = ALU_ADD;
          end
          {7'b0100000, 3'b000}: begin
            cls_d = C_RTYPE;
            rop_d = ALU_SUB;
          end
          {7'b0000000, 3'b111}: begin
            cls_d = C_RTYPE;
            rop_d = ALU_AND;
          end
          {7'b0000000, 3'b110}: begin
            cls_d = C_RTYPE;
            rop_d = ALU_OR;
          end
          default: ;
        endcase
      end
      opc == OP_I: begin
        if (f3 == 3'b000) cls_d = C_ADDI;
      end
      opc == OP_BR: begin
        if (f3 == 3'b000) cls_d = C_BEQ;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_d = '0;
    alu_d = ALU_ADD;
    unique case (cls_d)
      C_LOAD, C_ADDI: begin
        imm_d = {{(WORDSIZE-12){instr_d[31]}},
                 instr_d[31:20]};
      end
      C_STORE: begin
        imm_d = {{(WORDSIZE-12){instr_d[31]}},
                 instr_d[31:25], instr_d[11:7]};
      end
      C_BEQ: begin
        imm_d = {{(WORDSIZE-13){instr_d[31]}},
                 instr_d[31], instr_d[7],
                 instr_d[30:25], instr_d[11:8], 1'b0};
        alu_d = ALU_SUB;
      end
      C_RTYPE: alu_d = rop_d;
      default: ;
    endcase
  end

  // Outputs are registered from the next state and next latched word,
  // so each one is a clean function of the current state/instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cls_q   <= C_ILL;
      instr_q <= '0;
      ready_q <= 1'b1;
      ill_q   <= 1'b0;
      rf_we_q <= 1'b0;
      dm_re_q <= 1'b0;
      dm_we_q <= 1'b0;
      mux1_q  <= 1'b0;
      mux2_q  <= 1'b0;
      alu_q   <= ALU_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      rw_q    <= '0;
      imm_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      instr_q <= instr_d;
      ready_q <= (state_d == FETCH);
      ill_q   <= (state_d == DECODE) && (cls_d == C_ILL);
      rf_we_q <= (state_d == WRITEBACK);
      dm_re_q <= (state_d == MEMORY) && (cls_d == C_LOAD);
      dm_we_q <= (state_d == MEMORY) && (cls_d == C_STORE);
      mux1_q  <= cls_d inside {C_LOAD, C_STORE, C_ADDI};
      mux2_q  <= (cls_d == C_LOAD);
      alu_q   <= alu_d;
      ra_q    <= instr_d[19:15];
      rb_q    <= instr_d[24:20];
      rw_q    <= instr_d[11:7];
      imm_q   <= imm_d;
      if (retire) ret_q <= ret_q + CNT_WIDTH'(1);
    end
  end

  assign bus.cu_instr_ready   = ready_q;
  assign bus.cu_illegal       = ill_q;
  assign bus.cu_rf_write_en   = rf_we_q;
  assign bus.cu_dm_read_en    = dm_re_q;
  assign bus.cu_dm_write_en   = dm_we_q;
  assign bus.cu_mux_0_sel     = 1'b0;
  assign bus.cu_mux_1_sel     = mux1_q;
  assign bus.cu_mux_2_sel     = mux2_q;
  assign bus.cu_alu_operation = alu_q;
  assign bus.cu_rf_addr_a     = ra_q;
  assign bus.cu_rf_addr_b     = rb_q;
  assign bus.cu_rf_write_addr = rw_q;
  assign bus.cu_immediate     = imm_q;
  assign bus.cu_retired       = ret_q;

  // alu_zero is only known during EXECUTE, so the branch pulse is
  // decoded live in that state rather than registered.
  assign bus.cu_branch_taken = (state_q == EXECUTE) &&
                               (cls_q == C_BEQ) && bus.alu_zero;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed vectors push
// expected events; a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

  localparam int WS = 64;
  localparam int IS = 32;
  localparam int CW = 3;
  localparam int RMOD = 1 << CW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(
    .WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .CNT_WIDTH(CW)
  ) bus ();

  multicycle_control_unit #(
    .WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef enum int {K_WB, K_RD, K_WR, K_ILL, K_BR, K_DONE} kind_e;

  typedef struct {
    kind_e       k;
    logic [4:0]  a, b, w;
    logic [2:0]  op;
    logic        m1, m2, ab;
    logic [63:0] imm;
    int          n;
  } ev_t;

  typedef enum int {V_R, V_I, V_LD, V_ST, V_BR, V_ILL} vc_e;

  typedef struct {
    logic [31:0] ins;
    vc_e         c;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  op;
    logic [63:0] imm;
    int          w;
    bit          z;
  } vec_t;

  ev_t  q[$];
  vec_t tbl[15];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ret = 0;
  int   cur_w = 0;
  int   memcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(kind_e k, logic [4:0] a, logic [4:0] b,
                             logic [4:0] w, logic [2:0] op, logic m1,
                             logic m2, logic ab, logic [63:0] imm, int n);
    ev_t e;
    e.k = k; e.a = a; e.b = b; e.w = w; e.op = op;
    e.m1 = m1; e.m2 = m2; e.ab = ab; e.imm = imm; e.n = n;
    return e;
  endfunction

  task automatic take(input kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    e = mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (q.size() == 0) begin
      chk($sformatf("unexpected_event_%s", k.name()), 1, 0);
    end else begin
      e = q.pop_front();
      chk($sformatf("event_kind_%s", k.name()), e.k, k);
      ok = (e.k == k);
    end
  endtask

  // Data memory model: dm_ready low for cur_w strobe cycles, then high.
  always @(posedge clk) begin
    #2;
    if (bus.cu_dm_read_en || bus.cu_dm_write_en) begin
      bus.dm_ready = (memcnt == cur_w);
      memcnt++;
    end else begin
      bus.dm_ready = 1'b0;
      memcnt = 0;
    end
  end

  // Monitor.
  bit busy = 0;
  int lat = 0;
  int lowc = 0;
  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (!rst_n) begin
      busy = 0; lat = 0; lowc = 0;
    end else begin
      if ((bus.cu_dm_read_en || bus.cu_dm_write_en) && !bus.dm_ready)
        lowc++;
      if ((bus.cu_dm_read_en || bus.cu_dm_write_en) && bus.dm_ready) begin
        take(bus.cu_dm_read_en ? K_RD : K_WR, e, ok);
        if (ok) begin
          chk("mem_imm", bus.cu_immediate, e.imm);
          chk("mem_wait_cycles", lowc, e.n);
          chk("mem_alu_op", bus.cu_alu_operation, e.op);
          chk("mem_mux1", bus.cu_mux_1_sel, e.m1);
        end
        lowc = 0;
      end
      if (bus.cu_rf_write_en) begin
        take(K_WB, e, ok);
        if (ok) begin
          chk("wb_write_addr", bus.cu_rf_write_addr, e.w);
          chk("wb_mux2", bus.cu_mux_2_sel, e.m2);
          chk("wb_mux1", bus.cu_mux_1_sel, e.m1);
          chk("wb_mux0", bus.cu_mux_0_sel, 0);
          chk("wb_alu_op", bus.cu_alu_operation, e.op);
          chk("wb_imm", bus.cu_immediate, e.imm);
          if (e.ab) begin
            chk("wb_addr_a", bus.cu_rf_addr_a, e.a);
            chk("wb_addr_b", bus.cu_rf_addr_b, e.b);
          end
        end
      end
      if (bus.cu_illegal) take(K_ILL, e, ok);
      if (bus.cu_branch_taken) begin
        take(K_BR, e, ok);
        if (ok) begin
          chk("br_imm", bus.cu_immediate, e.imm);
          chk("br_alu_op", bus.cu_alu_operation, e.op);
          chk("br_mux1", bus.cu_mux_1_sel, e.m1);
        end
      end
      if (busy && bus.cu_instr_ready) begin
        take(K_DONE, e, ok);
        if (ok) begin
          chk("latency", lat, e.n);
          chk("retired", bus.cu_retired, e.imm);
        end
        busy = 0;
      end else if (busy) begin
        lat++;
      end else if (bus.instr_valid && bus.cu_instr_ready) begin
        busy = 1;
        lat = 1;
      end
    end
  end

  task automatic push_exp(input vec_t v);
    unique case (v.c)
      V_R: begin
        q.push_back(mk(K_WB, v.rs1, v.rs2, v.rd, v.op, 0, 0, 1, 0, 0));
        ret = (ret + 1) % RMOD;
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 64'(ret), 4));
      end
      V_I: begin
        q.push_back(mk(K_WB, 0, 0, v.rd, 3'b000, 1, 0, 0, v.imm, 0));
        ret = (ret + 1) % RMOD;
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 64'(ret), 4));
      end
      V_LD: begin
        q.push_back(mk(K_RD, 0, 0, 0, 3'b000, 1, 0, 0, v.imm, v.w));
        q.push_back(mk(K_WB, 0, 0, v.rd, 3'b000, 1, 1, 0, v.imm, 0));
        ret = (ret + 1) % RMOD;
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 64'(ret), 5 + v.w));
      end
      V_ST: begin
        q.push_back(mk(K_WR, 0, 0, 0, 3'b000, 1, 0, 0, v.imm, v.w));
        ret = (ret + 1) % RMOD;
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 64'(ret), 4 + v.w));
      end
      V_BR: begin
        if (v.z)
          q.push_back(mk(K_BR, 0, 0, 0, 3'b001, 0, 0, 0, v.imm, 0));
        ret = (ret + 1) % RMOD;
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 64'(ret), 3));
      end
      default: begin
        q.push_back(mk(K_ILL, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 64'(ret), 2));
      end
    endcase
  endtask

  task automatic run(input vec_t v);
    bit done;
    @(negedge clk);
    bus.instruction = v.ins;
    bus.instr_valid = 1'b1;
    bus.alu_zero = v.z;
    cur_w = v.w;
    push_exp(v);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'hFFFF_FFFF;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.cu_instr_ready) done = 1;
    end
    if (!done) chk($sformatf("timeout_%08h", v.ins), 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tbl[0]  = '{32'h007981B3, V_R, 5'd19, 5'd7, 5'd3, 3'b000, 64'd0, 0, 0};
    tbl[1]  = '{32'h41FC8333, V_R, 5'd25, 5'd31, 5'd6, 3'b001, 64'd0, 0, 0};
    tbl[2]  = '{32'h00317233, V_R, 5'd2, 5'd3, 5'd4, 3'b010, 64'd0, 0, 0};
    tbl[3]  = '{32'h00316233, V_R, 5'd2, 5'd3, 5'd4, 3'b011, 64'd0, 0, 0};
    tbl[4]  = '{32'hFFF08293, V_I, 5'd1, 5'd0, 5'd5, 3'b000,
                64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    tbl[5]  = '{32'h06B38183, V_LD, 5'd7, 5'd0, 5'd3, 3'b000, 64'd107, 3, 0};
    tbl[6]  = '{32'hB67981A3, V_ST, 5'd19, 5'd7, 5'd0, 3'b000,
                64'hFFFF_FFFF_FFFF_FB63, 2, 0};
    tbl[7]  = '{32'h06B38183, V_LD, 5'd7, 5'd0, 5'd3, 3'b000, 64'd107, 0, 0};
    tbl[8]  = '{32'hFE208CE3, V_BR, 5'd1, 5'd2, 5'd0, 3'b001,
                64'hFFFF_FFFF_FFFF_FFF8, 0, 1};
    tbl[9]  = '{32'hFE208CE3, V_BR, 5'd1, 5'd2, 5'd0, 3'b001,
                64'hFFFF_FFFF_FFFF_FFF8, 0, 0};
    tbl[10] = '{32'h0000007F, V_ILL, 5'd0, 5'd0, 5'd0, 3'b000, 64'd0, 0, 0};
    tbl[11] = '{32'h027981B3, V_ILL, 5'd0, 5'd0, 5'd0, 3'b000, 64'd0, 0, 0};
    tbl[12] = '{32'hFFF09293, V_ILL, 5'd0, 5'd0, 5'd0, 3'b000, 64'd0, 0, 0};
    tbl[13] = '{32'hFE209CE3, V_ILL, 5'd0, 5'd0, 5'd0, 3'b000, 64'd0, 0, 0};
    tbl[14] = '{32'hB67981A3, V_ST, 5'd19, 5'd7, 5'd0, 3'b000,
                64'hFFFF_FFFF_FFFF_FB63, 0, 0};

    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.alu_zero = 1'b0;
    bus.dm_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", bus.cu_instr_ready, 1);
    chk("rst_retired", bus.cu_retired, 0);
    chk("rst_rf_we", bus.cu_rf_write_en, 0);
    chk("rst_dm_en", {bus.cu_dm_read_en, bus.cu_dm_write_en}, 0);
    chk("rst_illegal", bus.cu_illegal, 0);
    chk("rst_imm", bus.cu_immediate, 0);
    chk("rst_alu", bus.cu_alu_operation, 0);
    chk("rst_addr", {bus.cu_rf_addr_a, bus.cu_rf_addr_b,
                     bus.cu_rf_write_addr}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Two passes so the 3-bit retire counter wraps.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 15; i++) run(tbl[i]);

    // Reset during a load's memory wait.
    @(negedge clk);
    bus.instruction = 32'h06B38183;
    bus.instr_valid = 1'b1;
    cur_w = 1000;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.cu_dm_read_en) seen = 1;
    end
    chk("mid_rst_reached_mem", seen, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dm_read", bus.cu_dm_read_en, 0);
    chk("mid_rst_rf_we", bus.cu_rf_write_en, 0);
    chk("mid_rst_ready", bus.cu_instr_ready, 1);
    chk("mid_rst_retired", bus.cu_retired, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ret = 0;
    cur_w = 0;

    run(tbl[0]);
    run(tbl[5]);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, data/immediate width.
REQ-002 SHALL have parameter INSTRUCTION_SIZE, default 32, instruction width (fixed 32 for RISC-V).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the retired-instruction counter.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instruction  in  INSTRUCTION_SIZE  instruction word from fetch.
- instr_valid  in  1  instruction word valid.
- cu_instr_ready  out  1  unit accepts an instruction.
- dm_ready  in  1  data memory completed the access.
- alu_zero  in  1  ALU result is zero.
- cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr  out  5 each  register file selects.
- cu_rf_write_en  out  1  register file write enable.
- cu_immediate  out  WORDSIZE  sign-extended immediate.
- cu_mux_0_sel  out  1  ALU A select (0 = rf A); held 0 for all supported ops.
- cu_mux_1_sel  out  1  ALU B select (0 = rf B, 1 = immediate).
- cu_mux_2_sel  out  1  rf write data select (0 = ALU, 1 = data memory).
- cu_alu_operation  out  3  000 ADD, 001 SUB, 010 AND, 011 OR.
- cu_dm_write_en, cu_dm_read_en  out  1 each  data memory strobes.
- cu_branch_taken  out  1  one-cycle pulse, PC loads branch target.
- cu_illegal  out  1  one-cycle pulse, unsupported instruction.
- cu_retired  out  CNT_WIDTH  retired-instruction count.

Function
REQ-005 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
REQ-006 SHALL assert cu_instr_ready only in FETCH; on instr_valid && cu_instr_ready, latch instruction and go to DECODE; otherwise stay in FETCH.
REQ-007 SHALL drive all outputs from state and the latched instruction only; a change on the instruction port after acceptance has no effect.
REQ-008 In DECODE, SHALL go to EXECUTE for opcodes 0000011 (load), 0100011 (store), 0110011 (R-type), 0010011 (ADDI), 1100011 (BEQ); for any other opcode or funct, SHALL pulse cu_illegal and go to FETCH without retiring.
REQ-009 R-type: funct7/funct3 0000000/000 ADD, 0100000/000 SUB, 0000000/111 AND, 0000000/110 OR; other combinations illegal. ADDI and BEQ require funct3 000, else illegal.
REQ-010 Immediates, sign-extended to WORDSIZE: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; R-type = 0.
REQ-011 EXECUTE: load/store/ADDI use ADD with cu_mux_1_sel=1; R-type uses the decoded op with cu_mux_1_sel=0; BEQ uses SUB with cu_mux_1_sel=0.
REQ-012 From EXECUTE: load/store -> MEMORY; R-type/ADDI -> WRITEBACK; BEQ -> FETCH, pulsing cu_branch_taken when alu_zero=1.
REQ-013 MEMORY: hold cu_dm_read_en (load) or cu_dm_write_en (store) until dm_ready=1; load then -> WRITEBACK, store -> FETCH; no timeout.
REQ-014 WRITEBACK: assert cu_rf_write_en for one cycle with cu_mux_2_sel=1 for load and 0 otherwise, then -> FETCH; rd=0 still asserts the strobe (the register file ignores x0).
REQ-015 Latencies in cycles, from acceptance to return to FETCH: R-type/ADDI 4, BEQ 3, load 5+w, store 4+w, illegal 2, where w is the number of dm_ready=0 cycles.
REQ-016 cu_retired SHALL increment by 1 on the cycle that leaves WRITEBACK, leaves MEMORY for a store, or leaves EXECUTE for a BEQ; it wraps from all-ones to 0.
REQ-017 Enables and pulses SHALL be 0 in every state not listed for them.

Reset
REQ-018 rst_n=0 SHALL immediately force state FETCH, latched instruction 0, cu_retired 0, every other output 0, and cu_instr_ready 1 once in FETCH.
REQ-019 Reset mid-instruction SHALL abort it with no write enable asserted and no retire count.

Verification
REQ-020 Accept 0x007981B3 (add x3,x19,x7) -> EXECUTE: addr_a=10011, addr_b=00111, alu=000, mux_1=0; WRITEBACK: write_addr=00011, rf_write_en=1, mux_2=0; retired=1.
REQ-021 Accept 0x41FC8333 (sub x6,x25,x31) -> alu=001, write_addr=00110, 4 cycles.
REQ-022 Accept 0x06B38183 (load), dm_ready low 3 cycles -> imm=107, dm_read_en held 3 cycles, then rf_write_en with mux_2=1; 8 cycles total.
REQ-023 Accept 0xB67981A3 (store) -> imm=0xFFFF_FFFF_FFFF_FB63, dm_write_en until dm_ready, no rf_write_en.
REQ-024 Opcode 1111111 -> cu_illegal pulse, FETCH after 2 cycles, retired unchanged; BEQ with alu_zero=1 -> cu_branch_taken pulse.
REQ-025 rst_n low during a load's MEMORY wait -> all enables 0 at once, FETCH, retired=0.
